// File: rtl/wb_regfile_sb.sv
// LC-3 writeback stage: source select, register file, N/Z/P status and a
// per-register busy scoreboard with optional write-through forwarding to
// the two decode read ports.
module wb_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [1:0]        wb_sel,
  input  logic [AW-1:0]     wb_dr,
  input  logic              wb_setcc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] npc,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_dr,
  input  logic [AW-1:0]     sr1,
  input  logic [AW-1:0]     sr2,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic              sr1_busy,
  output logic              sr2_busy,
  output logic [2:0]        psr,
  output logic              sb_err
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [2:0]          psr_q;
  logic [2:0]          psr_d;
  logic                sb_err_q;
  logic                sb_err_d;
  logic [DATA_W-1:0]   wr_data;

  // Writeback source select.
  always_comb begin
    wr_data = aluout;
    case (wb_sel)
      2'd0:    wr_data = aluout;
      2'd1:    wr_data = memout;
      2'd2:    wr_data = pcout;
      default: wr_data = npc;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // Next value of one register and its busy bit; a new issue outranks a
      // same-cycle writeback because the newer instruction is still pending.
      always_comb begin
        regs_d[gi] = regs_q[gi];
        busy_d[gi] = busy_q[gi];
        if (wb_valid && (wb_dr == AW'(gi))) begin
          regs_d[gi] = wr_data;
          busy_d[gi] = 1'b0;
        end
        if (issue_valid && (issue_dr == AW'(gi))) begin
          busy_d[gi] = 1'b1;
        end
      end

      // Register storage; reset clears contents.
      always_ff @(posedge clock) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  // Status flags and sticky scoreboard error, judged on the pre-update busy bit.
  always_comb begin
    psr_d    = psr_q;
    sb_err_d = sb_err_q;
    if (wb_valid && wb_setcc) begin
      if (wr_data[DATA_W-1])    psr_d = 3'b100;
      else if (wr_data == '0)   psr_d = 3'b010;
      else                      psr_d = 3'b001;
    end
    if (wb_valid && !busy_q[wb_dr]) begin
      sb_err_d = 1'b1;
    end
  end

  // Scoreboard, status and error flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= '0;
      psr_q    <= 3'b000;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      psr_q    <= psr_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Read ports with optional forwarding of this cycle's writeback; a source
  // being written (and not re-issued this cycle) is reported as not busy.
  always_comb begin
    d1       = regs_q[sr1];
    d2       = regs_q[sr2];
    sr1_busy = busy_q[sr1];
    sr2_busy = busy_q[sr2];
    if (BYPASS != 0) begin
      if (wb_valid && (wb_dr == sr1)) begin
        d1 = wr_data;
        if (!(issue_valid && (issue_dr == sr1))) sr1_busy = 1'b0;
      end
      if (wb_valid && (wb_dr == sr2)) begin
        d2 = wr_data;
        if (!(issue_valid && (issue_dr == sr2))) sr2_busy = 1'b0;
      end
    end
  end

  assign psr    = psr_q;
  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: a forwarding instance and a
// non-forwarding instance share the same stimulus.
module tb_wb_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_dr;
  logic        wb_setcc;
  logic [15:0] aluout, memout, pcout, npc;
  logic        issue_valid;
  logic [2:0]  issue_dr;
  logic [2:0]  sr1, sr2;
  logic [15:0] d1, d2, d1n, d2n;
  logic        sr1_busy, sr2_busy, sr1_busyn, sr2_busyn;
  logic [2:0]  psr, psrn;
  logic        sb_err, sb_errn;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  wb_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .wb_dr(wb_dr), .wb_setcc(wb_setcc), .aluout(aluout), .memout(memout),
    .pcout(pcout), .npc(npc), .issue_valid(issue_valid), .issue_dr(issue_dr),
    .sr1(sr1), .sr2(sr2), .d1(d1), .d2(d2), .sr1_busy(sr1_busy),
    .sr2_busy(sr2_busy), .psr(psr), .sb_err(sb_err)
  );

  wb_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .wb_dr(wb_dr), .wb_setcc(wb_setcc), .aluout(aluout), .memout(memout),
    .pcout(pcout), .npc(npc), .issue_valid(issue_valid), .issue_dr(issue_dr),
    .sr1(sr1), .sr2(sr2), .d1(d1n), .d2(d2n), .sr1_busy(sr1_busyn),
    .sr2_busy(sr2_busyn), .psr(psrn), .sb_err(sb_errn)
  );

  typedef struct packed {
    logic        iv;
    logic [2:0]  idr;
    logic        wv;
    logic [1:0]  sel;
    logic [2:0]  wdr;
    logic        setcc;
    logic [15:0] alu;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic [2:0]  psr;
    logic        err;
    logic [15:0] d1n;
    logic        b1n;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //           iv idr wv sel wdr cc alu       sr1 sr2 d1        d2        b1 b2 psr     err d1n       b1n
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 16'h0000, 0};
    vecs[1]  = '{1, 2, 0, 0, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 1, 0, 3'b000, 0, 16'h0000, 1};
    vecs[2]  = '{1, 3, 0, 0, 0, 0, 16'h0000, 2, 3, 16'h0000, 16'h0000, 1, 0, 3'b000, 0, 16'h0000, 1};
    vecs[3]  = '{1, 4, 0, 0, 0, 0, 16'h0000, 3, 4, 16'h0000, 16'h0000, 1, 0, 3'b000, 0, 16'h0000, 1};
    vecs[4]  = '{0, 0, 1, 0, 1, 1, 16'h1111, 1, 2, 16'h1111, 16'h0000, 0, 1, 3'b000, 0, 16'h0000, 1};
    vecs[5]  = '{0, 0, 1, 1, 2, 1, 16'h1111, 1, 2, 16'h1111, 16'h2222, 0, 0, 3'b001, 0, 16'h1111, 0};
    vecs[6]  = '{0, 0, 1, 2, 3, 1, 16'h1111, 3, 2, 16'h3333, 16'h2222, 0, 0, 3'b001, 0, 16'h0000, 1};
    vecs[7]  = '{0, 0, 1, 3, 4, 1, 16'h1111, 4, 3, 16'h4444, 16'h3333, 0, 0, 3'b001, 0, 16'h0000, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 4, 1, 16'h4444, 16'h1111, 0, 0, 3'b001, 0, 16'h4444, 0};
    vecs[9]  = '{1, 6, 0, 0, 0, 0, 16'h0000, 6, 6, 16'h0000, 16'h0000, 0, 0, 3'b001, 0, 16'h0000, 0};
    vecs[10] = '{1, 6, 1, 0, 6, 1, 16'h8000, 6, 6, 16'h8000, 16'h8000, 1, 1, 3'b001, 0, 16'h0000, 1};
    vecs[11] = '{1, 6, 1, 0, 6, 1, 16'h0000, 6, 6, 16'h0000, 16'h0000, 1, 1, 3'b100, 0, 16'h8000, 1};
    vecs[12] = '{0, 0, 1, 0, 6, 0, 16'h0005, 6, 6, 16'h0005, 16'h0005, 0, 0, 3'b010, 0, 16'h0000, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 16'h0000, 6, 6, 16'h0005, 16'h0005, 0, 0, 3'b010, 0, 16'h0005, 0};
    vecs[14] = '{1, 7, 0, 0, 0, 0, 16'h0000, 7, 7, 16'h0000, 16'h0000, 0, 0, 3'b010, 0, 16'h0000, 0};
    vecs[15] = '{0, 0, 1, 0, 7, 0, 16'hBEEF, 7, 7, 16'hBEEF, 16'hBEEF, 0, 0, 3'b010, 0, 16'h0000, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 16'h0000, 7, 7, 16'hBEEF, 16'hBEEF, 0, 0, 3'b010, 0, 16'hBEEF, 0};
    vecs[17] = '{1, 2, 0, 0, 0, 0, 16'h0000, 2, 2, 16'h2222, 16'h2222, 0, 0, 3'b010, 0, 16'h2222, 0};
    vecs[18] = '{1, 2, 1, 0, 2, 0, 16'h0AAA, 2, 2, 16'h0AAA, 16'h0AAA, 1, 1, 3'b010, 0, 16'h2222, 1};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 16'h0000, 2, 2, 16'h0AAA, 16'h0AAA, 1, 1, 3'b010, 0, 16'h0AAA, 1};
    vecs[20] = '{0, 0, 1, 0, 2, 0, 16'h0BBB, 2, 2, 16'h0BBB, 16'h0BBB, 0, 0, 3'b010, 0, 16'h0AAA, 1};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 16'h0000, 2, 2, 16'h0BBB, 16'h0BBB, 0, 0, 3'b010, 0, 16'h0BBB, 0};
    vecs[22] = '{0, 0, 1, 0, 5, 0, 16'h5555, 5, 5, 16'h5555, 16'h5555, 0, 0, 3'b010, 0, 16'h0000, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 16'h0000, 5, 5, 16'h5555, 16'h5555, 0, 0, 3'b010, 1, 16'h5555, 0};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 16'h0000, 5, 2, 16'h5555, 16'h0BBB, 0, 0, 3'b010, 1, 16'h5555, 0};

    // Reset held two cycles while a write of FFFF to R3 and an issue are offered.
    reset = 1'b1; wb_valid = 1'b1; wb_sel = 2'd0; wb_dr = 3'd3; wb_setcc = 1'b1;
    aluout = 16'hFFFF; memout = 16'h2222; pcout = 16'h3333; npc = 16'h4444;
    issue_valid = 1'b1; issue_dr = 3'd3; sr1 = 3'd0; sr2 = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; wb_valid = 1'b0; issue_valid = 1'b0; wb_setcc = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      @(negedge clock);
      chk("rst_d1", i, {16'h0, d1}, 32'h0);
      chk("rst_d2", i, {16'h0, d2}, 32'h0);
      chk("rst_busy", i, {30'h0, sr1_busy, sr2_busy}, 32'h0);
      chk("rst_psr", i, {29'h0, psr}, 32'h0);
      chk("rst_err", i, {31'h0, sb_err}, 32'h0);
      chk("rst_nb_d1", i, {16'h0, d1n}, 32'h0);
      $display("reset read sr1=%0d d1=%h d2=%h psr=%b err=%b", i, d1, d2, psr, sb_err);
      @(posedge clock);
      #1;
    end

    for (int v = 0; v < NV; v++) begin
      issue_valid = vecs[v].iv;  issue_dr = vecs[v].idr;
      wb_valid = vecs[v].wv;     wb_sel = vecs[v].sel;
      wb_dr = vecs[v].wdr;       wb_setcc = vecs[v].setcc;
      aluout = vecs[v].alu;      sr1 = vecs[v].sr1;  sr2 = vecs[v].sr2;
      @(negedge clock);
      chk("d1", v, {16'h0, d1}, {16'h0, vecs[v].d1});
      chk("d2", v, {16'h0, d2}, {16'h0, vecs[v].d2});
      chk("sr1_busy", v, {31'h0, sr1_busy}, {31'h0, vecs[v].b1});
      chk("sr2_busy", v, {31'h0, sr2_busy}, {31'h0, vecs[v].b2});
      chk("psr", v, {29'h0, psr}, {29'h0, vecs[v].psr});
      chk("sb_err", v, {31'h0, sb_err}, {31'h0, vecs[v].err});
      chk("nb_d1", v, {16'h0, d1n}, {16'h0, vecs[v].d1n});
      chk("nb_sr1_busy", v, {31'h0, sr1_busyn}, {31'h0, vecs[v].b1n});
      $display("vec %0d: d1=%h d2=%h b=%b%b psr=%b err=%b nb_d1=%h nb_b1=%b",
               v, d1, d2, sr1_busy, sr2_busy, psr, sb_err, d1n, sr1_busyn);
      @(posedge clock);
      #1;
    end

    // Reset mid-sequence: clears sticky error, psr and busy, discards the write.
    reset = 1'b1; wb_valid = 1'b1; wb_sel = 2'd0; wb_dr = 3'd5; wb_setcc = 1'b1;
    aluout = 16'hFFFF; issue_valid = 1'b1; issue_dr = 3'd5; sr1 = 3'd5; sr2 = 3'd7;
    @(posedge clock);
    #1;
    reset = 1'b0; wb_valid = 1'b0; issue_valid = 1'b0; wb_setcc = 1'b0;
    @(negedge clock);
    chk("rst2_err", 0, {31'h0, sb_err}, 32'h0);
    chk("rst2_psr", 0, {29'h0, psr}, 32'h0);
    chk("rst2_d1", 0, {16'h0, d1}, 32'h0);
    chk("rst2_d2", 0, {16'h0, d2}, 32'h0);
    chk("rst2_busy", 0, {31'h0, sr1_busy}, 32'h0);
    $display("reset2: d1=%h d2=%h psr=%b err=%b busy=%b", d1, d2, psr, sb_err, sr1_busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
